// File: rtl/serial_adder_if.sv
// Handshake and operand bus for serial_adder.
// SERIAL_ADDER_SUB_EN adds the sub (subtract mode) signal.
interface serial_adder_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             c_in;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             overflow;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, x, y, c_in, sub,
                  input  busy, done, s, c_out, overflow);
  modport slave  (input  start, x, y, c_in, sub,
                  output busy, done, s, c_out, overflow);
`else
  modport master (output start, x, y, c_in,
                  input  busy, done, s, c_out, overflow);
  modport slave  (input  start, x, y, c_in,
                  output busy, done, s, c_out, overflow);
`endif
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder: DIGIT bits per clock through a ripple chain of DIGIT
// full-adder cells, with a registered carry linking successive digits.
// SERIAL_ADDER_SUB_EN enables subtract mode (x + ~y + 1).
//
// state | meaning
// IDLE  | waiting for start
// RUN   | adding one digit per clock, STEPS cycles
// DONE  | result valid (done pulse); start here is accepted immediately
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic          clock,
  input logic          reset,
  serial_adder_if.slave bus
);
  localparam int STEPS  = WIDTH / DIGIT;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t            state, state_next;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  a_reg, b_reg, s_reg;
  logic              carry, c_out_reg, ovf_reg;
  logic [DIGIT-1:0]  dsum;
  logic [DIGIT:0]    chain;
  logic              accept, last_step;
  logic [WIDTH-1:0]  b_load;
  logic              carry_load;

  assign accept    = ((state == IDLE) || (state == DONE)) && bus.start;
  assign last_step = (state == RUN) && (step == STEP_W'(STEPS - 1));

  // Subtraction inverts B once at load time so the run loop stays add-only.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load     = bus.sub ? ~bus.y : bus.y;
  assign carry_load = bus.sub ? 1'b1 : bus.c_in;
`else
  assign b_load     = bus.y;
  assign carry_load = bus.c_in;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    state_next = bus.start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Ripple chain across the current digit; chain[DIGIT-1] is the carry into
  // the MSB on the final step, used for signed overflow.
  always_comb begin
    chain    = '0;
    dsum     = '0;
    chain[0] = carry;
    for (int i = 0; i < DIGIT; i++) begin
      dsum[i]    = a_reg[i] ^ b_reg[i] ^ chain[i];
      chain[i+1] = (a_reg[i] & b_reg[i]) | (chain[i] & (a_reg[i] ^ b_reg[i]));
    end
  end

  // Operand shift registers, carry, step counter and result registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_reg     <= '0;
      b_reg     <= '0;
      s_reg     <= '0;
      carry     <= 1'b0;
      step      <= '0;
      c_out_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (accept) begin
      a_reg <= bus.x;
      b_reg <= b_load;
      carry <= carry_load;
      s_reg <= '0;
      step  <= '0;
    end else if (state == RUN) begin
      a_reg <= a_reg >> DIGIT;
      b_reg <= b_reg >> DIGIT;
      carry <= chain[DIGIT];
      s_reg <= (s_reg >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
      step  <= step + STEP_W'(1);
      if (last_step) begin
        c_out_reg <= chain[DIGIT];
        ovf_reg   <= chain[DIGIT] ^ chain[DIGIT-1];
      end
    end
  end

  assign bus.busy     = (state == RUN);
  assign bus.done     = (state == DONE);
  assign bus.s        = s_reg;
  assign bus.c_out    = c_out_reg;
  assign bus.overflow = ovf_reg;
endmodule
